// File: rtl/dsd_adder_pkg.sv
// Shared encodings and widths for the adder operand sequencer.
// Pure declarations: no logic, no latency.
// No flow control; imported by the sequencer and its operand former.
package dsd_adder_pkg;

  localparam int OP_W  = 4;  // operand width
  localparam int SUM_W = 5;  // adder / accumulator width

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } seq_state_t;

endpackage : dsd_adder_pkg

// File: rtl/adder_operand_former.sv
// Maps accumulator and incoming operand onto the external 5-bit adder inputs.
// Purely combinational: zero latency.
// No flow control; optional subtract path enabled by ADD_SUB_MODE_EN.
module operand_former
  import dsd_adder_pkg::*;
(
  input  logic [SUM_W-1:0] i_acc,
  input  logic [OP_W-1:0]  i_data,
`ifdef ADD_SUB_MODE_EN
  input  logic             i_sub,
`endif
  output logic [OP_W-1:0]  o_add_a,
  output logic             o_add_a4,
  output logic [OP_W-1:0]  o_add_b,
  output logic             o_add_b4,
  output logic             o_add_cin
);

  // A side always carries the running total.
  assign o_add_a  = i_acc[OP_W-1:0];
  assign o_add_a4 = i_acc[SUM_W-1];

`ifdef ADD_SUB_MODE_EN
  // Subtract is acc + ~{0,data} + 1, i.e. two's complement of the zero-extended operand.
  assign o_add_b   = i_sub ? ~i_data : i_data;
  assign o_add_b4  = i_sub;
  assign o_add_cin = i_sub;
`else
  // Add only: operand zero-extended, no carry in.
  assign o_add_b   = i_data;
  assign o_add_b4  = 1'b0;
  assign o_add_cin = 1'b0;
`endif

endmodule : operand_former

// File: rtl/adder_operand_sequencer.sv
// Sums a burst of N_OPS 4-bit operands through an external adder; sticky overflow/borrow.
// One cycle per accepted operand; result_valid rises the cycle after the last beat.
// in_ready only in ACCUM; result held until result_ready. Optional sub port: ADD_SUB_MODE_EN.
module adder_operand_sequencer
  import dsd_adder_pkg::*;
#(
  parameter int N_OPS = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef ADD_SUB_MODE_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  input  logic [OP_W-1:0]  in_data,
  output logic             in_ready,
  output logic [OP_W-1:0]  add_a,
  output logic             add_a4,
  output logic [OP_W-1:0]  add_b,
  output logic             add_b4,
  output logic             add_cin,
  input  logic [SUM_W-1:0] add_sum,
  input  logic             add_carry,
  output logic             busy,
  output logic [SUM_W-1:0] result,
  output logic             result_ovf,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_OPS - 1);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  logic [SUM_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_result_valid;
  logic             w_accept;
  logic             w_start_burst;
  logic             w_sub_mode;
  logic             w_load_direct;
  logic             w_beat_ovf;

`ifdef ADD_SUB_MODE_EN
  logic r_sub;

  // Subtract mode is latched at burst start and held until the next burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sub <= 1'b0;
    end else if (w_start_burst) begin
      r_sub <= sub;
    end
  end

  assign w_sub_mode    = r_sub;
  // First subtract operand is the minuend: load it straight, bypassing the adder.
  assign w_load_direct = r_sub && (r_cnt == '0);
`else
  assign w_sub_mode    = 1'b0;
  assign w_load_direct = 1'b0;
`endif

  // In subtract mode a missing carry out means a borrow.
  assign w_beat_ovf    = w_sub_mode ? ~add_carry : add_carry;
  assign w_start_burst = (r_state == S_IDLE) && start;

  operand_former u_operand_former (
    .i_acc     (r_acc),
    .i_data    (in_data),
`ifdef ADD_SUB_MODE_EN
    .i_sub     (w_sub_mode),
`endif
    .o_add_a   (add_a),
    .o_add_a4  (add_a4),
    .o_add_b   (add_b),
    .o_add_b4  (add_b4),
    .o_add_cin (add_cin)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and beat-accept decode; start is only honoured in IDLE.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_ACCUM;
      end
      S_ACCUM: begin
        w_accept = in_valid;
        if (in_valid && (r_cnt == LAST_CNT)) w_next_state = S_DONE;
      end
      S_DONE: begin
        if (result_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Accumulator, beat counter, sticky flag and registered result_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc          <= '0;
      r_cnt          <= '0;
      r_ovf          <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= (w_next_state == S_DONE);
      if (w_start_burst) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_load_direct) begin
          r_acc <= {1'b0, in_data};
        end else begin
          r_acc <= add_sum;
          r_ovf <= r_ovf | w_beat_ovf;
        end
      end
    end
  end

  assign in_ready     = (r_state == S_ACCUM);
  assign busy         = (r_state == S_ACCUM);
  assign result_valid = r_result_valid;
  // Result is only presented while it is valid.
  assign result       = r_result_valid ? r_acc : '0;
  assign result_ovf   = r_result_valid ? r_ovf : 1'b0;

endmodule : adder_operand_sequencer
